// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals for mem_arbiter.
// slave = arbiter side, master = requesters plus memory (the environment).
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_mask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_mask, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_mask, mem_addr, mem_wdata, busy, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_mask, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_mask, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter onto one memory port; data wins unless fetch is starved.
// Define ARB_TIMEOUT_EN to abort stalled memory transactions and raise a sticky err.
module mem_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_DATA_BURST + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  if (MAX_DATA_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_arbiter: MAX_DATA_BURST and TIMEOUT_CYCLES must be >= 1");
  end

  state_t        r_state, w_next;
  logic          r_run;
  logic [SW-1:0] r_streak;
  logic [31:0]   r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic [3:0]    r_mask;
  logic          r_we, r_if_rvalid, r_d_rvalid;
  logic          w_streak_full, w_pick_if, w_if_gnt, w_d_gnt, w_mem_req;
  logic          w_ack, w_timeout, w_done;

  // Grants are held off until the first clock edge that sees reset released.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;

  assign w_streak_full = (r_streak == SW'(MAX_DATA_BURST));
  assign w_pick_if     = bus.if_req && (!bus.d_req || w_streak_full);
  assign w_ack         = (r_state != IDLE) && bus.mem_ack;
  assign w_done        = w_ack || w_timeout;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (r_run && (bus.if_req || bus.d_req)) w_next = w_pick_if ? FETCH : DATA;
      FETCH, DATA: if (w_done) w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    w_if_gnt  = 1'b0;
    w_d_gnt   = 1'b0;
    w_mem_req = 1'b0;
    if (r_state == IDLE) begin
      w_if_gnt = r_run && w_pick_if;
      w_d_gnt  = r_run && bus.d_req && !w_pick_if;
    end else begin
      w_mem_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)                           r_streak <= '0;
    else if (w_if_gnt)                  r_streak <= '0;
    else if (w_d_gnt && !bus.if_req)    r_streak <= '0;
    else if (w_d_gnt && !w_streak_full) r_streak <= r_streak + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_we        <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_if_gnt) begin
        r_addr  <= bus.if_addr;
        r_we    <= 1'b0;
        r_mask  <= 4'hF;
        r_wdata <= '0;
      end else if (w_d_gnt) begin
        r_addr  <= bus.d_addr;
        r_we    <= bus.d_we;
        r_mask  <= bus.d_mask;
        r_wdata <= bus.d_wdata;
      end
      if (w_done && r_state == FETCH) begin
        r_if_rdata  <= w_ack ? bus.mem_rdata : 32'h0000_0013;
        r_if_rvalid <= 1'b1;
      end
      if (w_done && r_state == DATA) begin
        // Stores leave the last load value visible.
        if (!w_ack)     r_d_rdata <= '0;
        else if (!r_we) r_d_rdata <= bus.mem_rdata;
        r_d_rvalid <= 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wait;
  logic          r_err;

  assign w_timeout = (r_state != IDLE) && !bus.mem_ack && (r_wait == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_if_gnt || w_d_gnt)  r_wait <= '0;
      else if (r_state != IDLE) r_wait <= r_wait + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_mask  = r_mask;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != IDLE);
endmodule
